// File: rtl/instruction_memory_pm.sv
// Instruction store shared by the CPU fetch port (run mode) and a req/ack
// programmer port (program mode); a mode FSM decides which side owns the array.
module instruction_memory_pm #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  prg_mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  addr_err,
  input  logic                  prg_req,
  input  logic                  prg_we,
  input  logic [ADDR_WIDTH-1:0] prg_addr,
  input  logic [DATA_WIDTH-1:0] prg_wd,
  output logic                  prg_ack,
  output logic [DATA_WIDTH-1:0] prg_rd,
  output logic                  prg_err,
  output logic                  mode_active,
  output logic [DEPTH_LOG2:0]   prg_count
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {RUN, PRG_IDLE, PRG_ACC, PRG_RESP} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [WORDS];
  logic                    lat_we;
  logic                    lat_in_range;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [DATA_WIDTH-1:0]   lat_wd;

  logic [DEPTH_LOG2-1:0]   fetch_idx;
  logic [DEPTH_LOG2-1:0]   prg_idx;
  logic                    fetch_ok;
  logic                    prg_ok;
  logic                    unused_byte_offsets;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (DEPTH_LOG2 + 2)) == '0;
  endfunction

  // Byte offsets within a word carry no meaning for a word-wide store.
  assign unused_byte_offsets = ^{addr[1:0], prg_addr[1:0]};

  assign fetch_idx = addr[DEPTH_LOG2+1:2];
  assign prg_idx   = prg_addr[DEPTH_LOG2+1:2];
  assign fetch_ok  = in_range(addr);
  assign prg_ok    = in_range(prg_addr);

  // The array has no reset; only the programmer side ever writes it.
  always_ff @(posedge clk) begin
    if (state == PRG_ACC && lat_we && lat_in_range)
      mem[lat_idx] <= lat_wd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      rd           <= '0;
      addr_err     <= 1'b0;
      prg_ack      <= 1'b0;
      prg_rd       <= '0;
      prg_err      <= 1'b0;
      mode_active  <= 1'b0;
      prg_count    <= '0;
      lat_we       <= 1'b0;
      lat_in_range <= 1'b0;
      lat_idx      <= '0;
      lat_wd       <= '0;
    end else begin
      prg_ack  <= 1'b0;
      rd       <= '0;
      addr_err <= 1'b0;
      case (state)
        RUN: begin
          rd       <= fetch_ok ? mem[fetch_idx] : '0;
          addr_err <= !fetch_ok;
          if (prg_mode) begin
            state       <= PRG_IDLE;
            prg_count   <= '0;
            mode_active <= 1'b1;
          end
        end
        PRG_IDLE: begin
          // A pending request always finishes before run mode is re-entered.
          if (prg_req) begin
            lat_we       <= prg_we;
            lat_in_range <= prg_ok;
            lat_idx      <= prg_idx;
            lat_wd       <= prg_wd;
            state        <= PRG_ACC;
          end else if (!prg_mode) begin
            state       <= RUN;
            mode_active <= 1'b0;
          end
        end
        PRG_ACC: begin
          if (lat_we) begin
            if (lat_in_range && prg_count != COUNT_MAX)
              prg_count <= prg_count + 1'b1;
          end else begin
            prg_rd <= lat_in_range ? mem[lat_idx] : '0;
          end
          prg_err <= !lat_in_range;
          prg_ack <= 1'b1;
          state   <= PRG_RESP;
        end
        PRG_RESP: state <= PRG_IDLE;
        default:  state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_pm.sv
// Randomised self-checking bench for instruction_memory_pm against a
// transaction-level model of the word store, write counter and mode rules.
module tb_instruction_memory_pm;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DL    = 8;
  localparam int WORDS = 1 << DL;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          prg_mode = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] rd;
  logic          addr_err;
  logic          prg_req = 1'b0;
  logic          prg_we = 1'b0;
  logic [AW-1:0] prg_addr = '0;
  logic [DW-1:0] prg_wd = '0;
  logic          prg_ack;
  logic [DW-1:0] prg_rd;
  logic          prg_err;
  logic          mode_active;
  logic [DL:0]   prg_count;

  instruction_memory_pm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset_n(reset_n), .prg_mode(prg_mode), .addr(addr), .rd(rd),
    .addr_err(addr_err), .prg_req(prg_req), .prg_we(prg_we), .prg_addr(prg_addr),
    .prg_wd(prg_wd), .prg_ack(prg_ack), .prg_rd(prg_rd), .prg_err(prg_err),
    .mode_active(mode_active), .prg_count(prg_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] model_mem [WORDS];
  bit            model_known [WORDS];
  int            model_count = 0;
  logic [DW-1:0] model_prg_rd = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    return a < 32'(WORDS * 4);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'(a / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return $urandom | 32'h0000_0400;
    return 32'($urandom_range(0, WORDS * 4 - 1));
  endfunction

  task automatic applyStimulus(input logic mode, input logic req, input logic we,
                               input logic [31:0] pa, input logic [31:0] wd);
    prg_mode = mode;
    prg_req  = req;
    prg_we   = we;
    prg_addr = pa;
    prg_wd   = wd;
  endtask

  // Every task starts and ends just after a falling edge.
  task automatic fetch_check(input logic [31:0] a);
    addr = a;
    @(negedge clk);
    checkOutput("fetch_err", 32'(addr_err), 32'(!m_in_range(a)));
    if (!m_in_range(a)) checkOutput("fetch_rd_oor", rd, 32'h0);
    else if (model_known[m_idx(a)]) checkOutput("fetch_rd", rd, model_mem[m_idx(a)]);
  endtask

  task automatic enter_prog();
    prg_mode = 1'b1;
    @(negedge clk);
    model_count = 0;
    checkOutput("enter_mode_active", 32'(mode_active), 32'h1);
    checkOutput("enter_count_clear", 32'(prg_count), 32'h0);
  endtask

  task automatic exit_prog();
    prg_mode = 1'b0;
    @(negedge clk);
    checkOutput("exit_mode_active", 32'(mode_active), 32'h0);
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (prg_ack !== 1'b1 && n < 12);
    checkOutput("ack_seen", 32'(prg_ack), 32'h1);
  endtask

  task automatic check_ack_outputs(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = m_in_range(a);
    if (we && ok) begin
      model_mem[m_idx(a)]   = d;
      model_known[m_idx(a)] = 1'b1;
      if (model_count < WORDS) model_count++;
    end
    if (!we) model_prg_rd = ok ? model_mem[m_idx(a)] : 32'h0;
    checkOutput("prg_err", 32'(prg_err), 32'(!ok));
    checkOutput("prg_rd", prg_rd, model_prg_rd);
    checkOutput("prg_count", 32'(prg_count), 32'(model_count));
    checkOutput("prg_mode_active", 32'(mode_active), 32'h1);
    checkOutput("cpu_nop_rd", rd, 32'h0);
  endtask

  task automatic prg_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n;
    applyStimulus(prg_mode, 1'b1, we, a, d);
    wait_ack(n);
    checkOutput("ack_latency", 32'(n), 32'd2);
    check_ack_outputs(we, a, d);
    prg_req = 1'b0;
    @(negedge clk);
    checkOutput("ack_one_cycle", 32'(prg_ack), 32'h0);
  endtask

  initial begin
    int n;
    logic [31:0] a1, a2, d1, d2;

    // Reset state
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    addr = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rd", rd, 32'h0);
    checkOutput("reset_addr_err", 32'(addr_err), 32'h0);
    checkOutput("reset_mode_active", 32'(mode_active), 32'h0);
    checkOutput("reset_prg_ack", 32'(prg_ack), 32'h0);
    checkOutput("reset_prg_rd", prg_rd, 32'h0);
    checkOutput("reset_prg_err", 32'(prg_err), 32'h0);
    checkOutput("reset_prg_count", 32'(prg_count), 32'h0);
    reset_n = 1'b1;
    fetch_check(32'h0);

    // Directed loader sequence
    enter_prog();
    prg_txn(1'b1, 32'h0, 32'h2402_0005);
    prg_txn(1'b1, 32'h4, 32'h0000_000C);
    prg_txn(1'b0, 32'h4, 32'h0);
    checkOutput("directed_read", prg_rd, 32'h0000_000C);
    exit_prog();
    fetch_check(32'h4);
    checkOutput("directed_fetch", rd, 32'h0000_000C);
    checkOutput("count_retained", 32'(prg_count), 32'd2);
    fetch_check(32'h400);

    // Programmer requests are ignored in run mode
    prg_req = 1'b1;
    prg_we  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("run_req_ignored", 32'(prg_ack), 32'h0);
    end
    prg_req = 1'b0;
    fetch_check(32'h0);

    // Out-of-range write, then fill the whole array and saturate the counter
    enter_prog();
    prg_txn(1'b1, 32'h400, 32'hDEAD_BEEF);
    for (int i = 0; i < WORDS; i++) prg_txn(1'b1, 32'(i * 4), $urandom);
    checkOutput("count_saturated", 32'(prg_count), 32'(WORDS));

    for (int i = 0; i < 40; i++) prg_txn(1'($urandom_range(0, 1)), rand_addr(), $urandom);

    // Mode drops in the same cycle the request rises
    a1 = 32'h0000_0010;
    d1 = $urandom;
    prg_mode = 1'b0;
    prg_txn(1'b1, a1, d1);
    @(negedge clk);
    checkOutput("drop_mode_to_run", 32'(mode_active), 32'h0);
    fetch_check(a1);

    for (int i = 0; i < 20; i++) fetch_check(rand_addr());

    // Back-to-back transactions with req held across ack
    enter_prog();
    a1 = 32'h0000_0020; d1 = $urandom;
    a2 = 32'h0000_0024; d2 = $urandom;
    applyStimulus(1'b1, 1'b1, 1'b1, a1, d1);
    wait_ack(n);
    checkOutput("b2b_first_latency", 32'(n), 32'd2);
    check_ack_outputs(1'b1, a1, d1);
    applyStimulus(1'b1, 1'b1, 1'b1, a2, d2);
    wait_ack(n);
    checkOutput("b2b_spacing", 32'(n), 32'd3);
    check_ack_outputs(1'b1, a2, d2);
    prg_req = 1'b0;
    @(negedge clk);

    // Reset during PRG_ACC aborts the transaction
    a1 = 32'h0000_0030;
    applyStimulus(1'b1, 1'b1, 1'b1, a1, $urandom);
    @(posedge clk);
    #2;
    reset_n  = 1'b0;
    prg_mode = 1'b0;
    prg_req  = 1'b0;
    #1;
    model_known[m_idx(a1)] = 1'b0;
    model_count  = 0;
    model_prg_rd = '0;
    checkOutput("abort_mode_active", 32'(mode_active), 32'h0);
    checkOutput("abort_prg_ack", 32'(prg_ack), 32'h0);
    checkOutput("abort_prg_count", 32'(prg_count), 32'h0);
    checkOutput("abort_prg_rd", prg_rd, 32'h0);
    checkOutput("abort_rd", rd, 32'h0);
    @(negedge clk);
    checkOutput("abort_no_ack", 32'(prg_ack), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) fetch_check(rand_addr());
    fetch_check(32'h4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory_pm.md
Name: instruction_memory_pm

Overview:
- Parametrised instruction memory with two masters sharing one single-port word array: the CPU fetch port (run mode) and a programmer port (program mode) driven by the Nios loader.
- A mode FSM arbitrates ownership. It defers mode changes until any programmer transaction has finished.
- Programmer accesses use a req/ack handshake. CPU fetches have fixed 1-cycle read latency.
- Adds range checking and a written-word counter for loader verification.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, byte-address width on both ports.
- DEPTH_LOG2, 8, log2 of the number of words (default 256 words).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- prg_mode  input  1  requested mode: 1 = program, 0 = run.
- addr  input  ADDR_WIDTH  CPU fetch byte address.
- rd  output  DATA_WIDTH  CPU fetch data, registered.
- addr_err  output  1  CPU fetch address out of range, registered alongside rd.
- prg_req  input  1  programmer transaction request, held until ack.
- prg_we  input  1  1 = write, 0 = read; sampled with prg_req.
- prg_addr  input  ADDR_WIDTH  programmer byte address.
- prg_wd  input  DATA_WIDTH  programmer write data.
- prg_ack  output  1  one-cycle completion pulse.
- prg_rd  output  DATA_WIDTH  programmer read data, valid when prg_ack is high on a read.
- prg_err  output  1  out-of-range flag, valid when prg_ack is high.
- mode_active  output  1  current effective mode: 1 = program.
- prg_count  output  DEPTH_LOG2+1  count of accepted in-range programmer writes since entering program mode.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to RUN.
  - rd, prg_rd, prg_count are 0; addr_err, prg_ack, prg_err, mode_active are 0.
  - Memory array contents are not reset.
- Word index = byte address [DEPTH_LOG2+1:2]; bits [1:0] are ignored. An address is in range iff its bits [ADDR_WIDTH-1:DEPTH_LOG2+2] are all zero.
- States: RUN, PRG_IDLE, PRG_ACC, PRG_RESP.
- RUN:
  - Each cycle, rd <= mem[word(addr)] if in range, else 0. addr_err <= out-of-range. Latency is 1 cycle.
  - prg_req is ignored and prg_ack stays 0.
  - If prg_mode=1: go to PRG_IDLE, clear prg_count to 0, set mode_active=1 at the same edge.
- PRG_IDLE:
  - rd <= 0 and addr_err <= 0 every cycle; the CPU sees NOP.
  - If prg_mode=0 and prg_req=0: go to RUN and clear mode_active.
  - Else if prg_req=1: latch prg_we, prg_addr, prg_wd and go to PRG_ACC. This applies even if prg_mode has dropped; the request completes before leaving.
- PRG_ACC: perform the access in this cycle.
  - Write, in range: mem updated and prg_count increments. prg_count saturates at 2^DEPTH_LOG2.
  - Write, out of range: no memory update, no count change.
  - Read: prg_rd <= mem[word] if in range, else 0.
  - prg_err <= out-of-range. prg_ack <= 1. Go to PRG_RESP.
- PRG_RESP:
  - prg_ack is high for exactly this one cycle; prg_rd and prg_err are valid.
  - Returns to PRG_IDLE unconditionally.
  - The master must deassert prg_req by the cycle after ack. A request still high in PRG_IDLE is treated as a new transaction.
- prg_rd and prg_err hold their last value until the next ack.
- Transaction latency, req to ack: 2 cycles when entered from PRG_IDLE. Throughput is 1 transaction per 3 cycles.
- Read-after-write to the same address returns the new data.
- CPU write enable is never asserted; run mode is read-only.
- Reset asserted mid-transaction aborts it: no ack is issued, and a write in PRG_ACC may or may not have landed.
- prg_count is retained when returning to RUN. It clears only on RUN→PRG_IDLE and on reset.

Test Plan:
- Reset, then prg_mode=0, addr=0x0 → rd=0, addr_err=0, mode_active=0 throughout reset. After release, rd reflects mem[0] one cycle after addr is applied.
- prg_mode=1, then write 0x2402_0005 at 0x0 and 0x0000_000C at 0x4 → prg_ack pulse 2 cycles after each req, prg_count=2, rd=0 while in program mode.
- Programmer read of 0x4 → prg_rd=0x0000_000C with prg_ack, prg_err=0. Then prg_mode=0 → mode_active=0 next cycle; fetch addr=0x4 → rd=0x0000_000C one cycle later; prg_count stays 2.
- Write to prg_addr=0x400 (out of range for DEPTH_LOG2=8) → prg_ack=1, prg_err=1, prg_count unchanged. CPU fetch addr=0x400 → rd=0, addr_err=1.
- Drop prg_mode in the same cycle prg_req rises → transaction completes with ack, then FSM returns to RUN. Assert reset_n=0 during PRG_ACC → all outputs 0 immediately, state RUN.
- Back-to-back writes with req held high across ack → second transaction accepted from PRG_IDLE, ack spacing 3 cycles.
